rr_arbiter_n: RTL

RR_ARBITER_N -- requirements
Module: rr_arbiter_n

---
 rtl/rr_arbiter_n.sv | 97 +++++++++
 1 files changed

// File: rtl/rr_arbiter_n.sv
// Round-robin arbiter with a per-grant burst limit. Grants one requester at a time and
// rotates after MAX_BURST transfers, on withdrawal, or drops to IDLE when nobody is asking.
module rr_arbiter_n #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         in_valid,
  input  logic                       in_ready,
  output logic [$clog2(NUM_REQ)-1:0] out_choice,
  output logic                       out_grant_valid,
  output logic [NUM_REQ-1:0]         out_stall
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [IDX_W:0]   NUM_W    = (IDX_W+1)'(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state;
  logic [IDX_W-1:0] choice;
  logic [IDX_W-1:0] last_idx;
  logic [CNT_W-1:0] cnt;

  logic [IDX_W-1:0] base, start, hit_idx;
  logic [IDX_W:0]   sum;
  logic             hit;

  // One search serves both decisions: IDLE scans after last_idx, GRANT after choice.
  always_comb begin
    base  = (state == IDLE) ? last_idx : choice;
    start = (base == LAST_IDX) ? '0 : base + 1'b1;
  end

  // Scan from the far end so the nearest valid index after start wins.
  always_comb begin
    hit     = 1'b0;
    hit_idx = start;
    sum     = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      sum = {1'b0, start} + (IDX_W+1)'(i);
      if (sum >= NUM_W) sum = sum - NUM_W;
      if (in_valid[sum[IDX_W-1:0]]) begin
        hit     = 1'b1;
        hit_idx = sum[IDX_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      choice   <= '0;
      last_idx <= LAST_IDX;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (hit) begin
            state  <= GRANT;
            choice <= hit_idx;
            cnt    <= '0;
          end
        end
        GRANT: begin
          if (!in_valid[choice]) begin
            last_idx <= choice;
            cnt      <= '0;
            if (hit) choice <= hit_idx;
            else     state  <= IDLE;
          end else if (in_ready) begin
            if (cnt == LAST_CNT) begin
              // Current owner is still valid, so the search always hits (possibly itself).
              choice   <= hit_idx;
              last_idx <= choice;
              cnt      <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    out_stall = '1;
    if (state == GRANT) out_stall[choice] = !in_ready;
  end

  assign out_choice      = choice;
  assign out_grant_valid = (state == GRANT);
endmodule
